// File: rtl/inst_rom_responder.sv
// Instruction-memory responder for the fetch stage.
// After reset a boot port fills the word array while the pipeline is stalled.
// Once the image is loaded, the block serves one-cycle-latency fetches and
// flags misaligned or out-of-range program counters.
module inst_rom_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_enable,
  input  logic [ADDR_WIDTH-1:0] program_counter,
  input  logic                  hold,
  input  logic                  load_valid,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [INST_WIDTH-1:0] load_data,
  input  logic                  load_done,
  output logic [INST_WIDTH-1:0] instruction,
  output logic                  inst_valid,
  output logic                  addr_error,
  output logic                  stall_request
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic LOAD  = 1'b0;
  localparam logic SERVE = 1'b1;

  logic                  state;
  logic [INST_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  misaligned;
  logic                  out_of_range;
  logic [DEPTH_LOG2-1:0] word_idx;

  // The range check looks at every bit above the word index, so an address
  // such as 0x1000 is an error and does not alias to word 0.
  assign misaligned   = program_counter[1:0] != 2'b00;
  assign out_of_range = (program_counter >> (DEPTH_LOG2 + 2)) != '0;
  assign word_idx     = program_counter[DEPTH_LOG2+1:2];

  // Two-state controller: LOAD until the boot port marks end of image.
  // SERVE can only be left through reset.
  always_ff @(posedge clock) begin
    if (reset)
      state <= LOAD;
    else if (state == LOAD && load_done)
      state <= SERVE;
  end

  // The stall flag tracks the next state, so it drops on the same edge that
  // enters SERVE.
  always_ff @(posedge clock) begin
    if (reset)
      stall_request <= 1'b1;
    else if (state == LOAD)
      stall_request <= !load_done;
    else
      stall_request <= 1'b0;
  end

  // Boot-port writes are accepted only in LOAD. The array is never cleared,
  // so the image survives a reset.
  always_ff @(posedge clock) begin
    if (!reset && state == LOAD && load_valid)
      mem[load_addr] <= load_data;
  end

  // Registered fetch response. In SERVE, hold freezes the outputs and drops
  // the request; the PC side re-presents the address after the stall.
  always_ff @(posedge clock) begin
    if (reset || state == LOAD) begin
      instruction <= '0;
      inst_valid  <= 1'b0;
      addr_error  <= 1'b0;
    end else if (!hold) begin
      if (!chip_enable) begin
        instruction <= '0;
        inst_valid  <= 1'b0;
        addr_error  <= 1'b0;
      end else if (misaligned || out_of_range) begin
        instruction <= '0;
        inst_valid  <= 1'b0;
        addr_error  <= 1'b1;
      end else begin
        instruction <= mem[word_idx];
        inst_valid  <= 1'b1;
        addr_error  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Directed bench for inst_rom_responder.
// A boot image is loaded, then a vector table of fetches is applied.
// Hand sequences follow for the boot-port-in-SERVE and reset-mid-SERVE cases.
module tb_inst_rom_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        chip_enable;
  logic [31:0] program_counter;
  logic        hold;
  logic        load_valid;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        addr_error;
  logic        stall_request;

  int n_total = 0;
  int n_pass  = 0;

  inst_rom_responder dut (
    .clock           (clock),
    .reset           (reset),
    .chip_enable     (chip_enable),
    .program_counter (program_counter),
    .hold            (hold),
    .load_valid      (load_valid),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_done       (load_done),
    .instruction     (instruction),
    .inst_valid      (inst_valid),
    .addr_error      (addr_error),
    .stall_request   (stall_request)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        ce;
    logic [31:0] pc;
    logic        hld;
    logic [31:0] exp_inst;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_out(input string name, input logic [31:0] ei, input logic ev, input logic ee);
    chk({name, ".instruction"}, instruction, ei);
    chk({name, ".inst_valid"}, {31'b0, inst_valid}, {31'b0, ev});
    chk({name, ".addr_error"}, {31'b0, addr_error}, {31'b0, ee});
  endtask

  task automatic load_word(input logic [9:0] a, input logic [31:0] d, input logic done);
    load_valid = 1'b1; load_addr = a; load_data = d; load_done = done;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; chip_enable = 1'b0; program_counter = '0; hold = 1'b0;
    load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;

    // Reset for two cycles, then idle.
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset.stall", {31'b0, stall_request}, 32'd1);
    chk_out("reset", 32'h0, 1'b0, 1'b0);

    // In LOAD, fetch requests and hold are ignored.
    chip_enable = 1'b1; program_counter = 32'h0; hold = 1'b1;
    tick();
    chk_out("load_ce_ignored", 32'h0, 1'b0, 1'b0);
    chip_enable = 1'b0; hold = 1'b0;

    // Boot image.
    load_word(10'd0,    32'h3C010001, 1'b0);
    load_word(10'd1,    32'h34210002, 1'b0);
    load_word(10'd2,    32'h00430820, 1'b0);
    load_word(10'd1023, 32'h12345678, 1'b0);
    chk("load.stall_held", {31'b0, stall_request}, 32'd1);
    // Last write coincides with load_done.
    load_word(10'd5,    32'hDEADBEEF, 1'b1);
    chk("load_done.stall_drop", {31'b0, stall_request}, 32'd0);
    chk_out("serve_entry", 32'h0, 1'b0, 1'b0);

    vecs.push_back('{"pc0",      1'b1, 32'h0000_0000, 1'b0, 32'h3C010001, 1'b1, 1'b0});
    vecs.push_back('{"pc4",      1'b1, 32'h0000_0004, 1'b0, 32'h34210002, 1'b1, 1'b0});
    vecs.push_back('{"pc14",     1'b1, 32'h0000_0014, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0});
    vecs.push_back('{"pc6",      1'b1, 32'h0000_0006, 1'b0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{"pc1000",   1'b1, 32'h0000_1000, 1'b0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{"pcffc",    1'b1, 32'h0000_0FFC, 1'b0, 32'h12345678, 1'b1, 1'b0});
    vecs.push_back('{"ce0",      1'b0, 32'h0000_0000, 1'b0, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{"pc4b",     1'b1, 32'h0000_0004, 1'b0, 32'h34210002, 1'b1, 1'b0});
    vecs.push_back('{"hold1",    1'b1, 32'h0000_0008, 1'b1, 32'h34210002, 1'b1, 1'b0});
    vecs.push_back('{"hold2",    1'b1, 32'h0000_0008, 1'b1, 32'h34210002, 1'b1, 1'b0});
    vecs.push_back('{"hold3",    1'b1, 32'h0000_0008, 1'b1, 32'h34210002, 1'b1, 1'b0});
    vecs.push_back('{"unhold",   1'b1, 32'h0000_0008, 1'b0, 32'h00430820, 1'b1, 1'b0});
    vecs.push_back('{"pc2",      1'b1, 32'h0000_0002, 1'b0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{"hold_err", 1'b1, 32'h0000_0000, 1'b1, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{"pc_hi",    1'b1, 32'h8000_0000, 1'b0, 32'h0,        1'b0, 1'b1});
    vecs.push_back('{"pc_alias", 1'b1, 32'h0000_1014, 1'b0, 32'h0,        1'b0, 1'b1});

    foreach (vecs[i]) begin
      chip_enable = vecs[i].ce; program_counter = vecs[i].pc; hold = vecs[i].hld;
      tick();
      chk_out(vecs[i].name, vecs[i].exp_inst, vecs[i].exp_valid, vecs[i].exp_err);
      chk({vecs[i].name, ".exclusive"}, {31'b0, inst_valid & addr_error}, 32'd0);
    end
    hold = 1'b0;

    // Boot port must be ignored in SERVE: the write attempt must not reach mem[0].
    chip_enable = 1'b1; program_counter = 32'h0;
    load_word(10'd0, 32'hFFFFFFFF, 1'b1);
    tick();
    chk_out("serve_ro", 32'h3C010001, 1'b1, 1'b0);
    chk("serve_ro.stall", {31'b0, stall_request}, 32'd0);

    // Reset mid-SERVE returns to LOAD with memory preserved.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid.stall", {31'b0, stall_request}, 32'd1);
    chk("rst_mid.valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk_out("rst_mid.load", 32'h0, 1'b0, 1'b0);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("reload.stall", {31'b0, stall_request}, 32'd0);
    chip_enable = 1'b1; program_counter = 32'h0;
    tick();
    chk_out("preserved", 32'h3C010001, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
